// File: rtl/switches_buttons_if.sv
// Device/command bus seen by the switch/button input peripheral.
// The CPU side drives device/command; the peripheral returns registered read data.
interface switches_buttons_if;
    logic [4:0]  device;
    logic [5:0]  command;
    logic [31:0] data_out;
    logic        rd_valid;

    modport master (output device, output command, input data_out, input rd_valid);
    modport slave  (input device, input command, output data_out, output rd_valid);
endinterface

// File: rtl/switches_buttons.sv
// Memory-mapped input peripheral: synchronizes switches, debounces buttons,
// latches sticky press events and returns them on bus read commands.
module switches_buttons #(
    parameter logic [4:0] DEV_ID          = 5'b00001,
    parameter int         DEBOUNCE_CYCLES = 250000,
    parameter int         CNT_W           = 18
) (
    input  logic                clk,
    input  logic                reset,
    switches_buttons_if.slave   bus,
    input  logic [7:0]          switches,
    input  logic [4:0]          buttons
);

    localparam logic [5:0] CMD_RD_SW   = 6'b000010;
    localparam logic [5:0] CMD_RD_BTN  = 6'b000011;
    localparam logic [5:0] CMD_RD_EVT  = 6'b000100;
    localparam logic [5:0] CMD_RD_STAT = 6'b000101;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]  sw_meta_q, sw_sync_q;
    logic [4:0]  btn_meta_q, btn_sync_q;
    logic [4:0]  btn_db;
    logic [4:0]  db_rise;
    logic [4:0]  evt_q, evt_d;
    logic        evt_clr;
    logic [31:0] data_out_q, data_out_d;
    logic        rd_valid_q, rd_valid_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            sw_meta_q  <= switches;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= buttons;
            btn_sync_q <= btn_meta_q;
        end
    end

    // Each button owns a counter that runs only while its synchronized level disagrees
    // with the accepted level; any agreement restarts the count.
    for (genvar gi = 0; gi < 5; gi++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             db_q, db_d;

        always_comb begin
            cnt_d = cnt_q;
            db_d  = db_q;
            if (btn_sync_q[gi] == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                db_d  = btn_sync_q[gi];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                db_q  <= db_d;
            end
        end

        assign btn_db[gi]  = db_q;
        assign db_rise[gi] = db_d & ~db_q;
    end

    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        evt_clr    = 1'b0;
        if (bus.device == DEV_ID) begin
            case (bus.command)
                CMD_RD_SW: begin
                    data_out_d = {24'd0, sw_sync_q};
                    rd_valid_d = 1'b1;
                end
                CMD_RD_BTN: begin
                    data_out_d = {27'd0, btn_db};
                    rd_valid_d = 1'b1;
                end
                CMD_RD_EVT: begin
                    data_out_d = {27'd0, evt_q};
                    rd_valid_d = 1'b1;
                    evt_clr    = 1'b1;
                end
                CMD_RD_STAT: begin
                    data_out_d = {16'd0, 3'd0, btn_db, sw_sync_q};
                    rd_valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A press landing on the clearing edge survives: set takes priority over clear.
    assign evt_d = db_rise | (evt_q & ~{5{evt_clr}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt_q      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            evt_q      <= evt_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_switches_buttons.sv
// Bench for switches_buttons: window-based behavioural model compared every cycle,
// plus directed literal checks from the test plan.
module tb_switches_buttons;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] switches;
    logic [4:0] buttons;

    switches_buttons_if bus_if();

    switches_buttons #(
        .DEV_ID(5'b00001),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if),
        .switches(switches),
        .buttons(buttons)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: sync level is the pin two edges back; a button's accepted level flips
    // once the last DEB synchronized samples all disagree with it.
    logic [7:0]  m_sw_meta, m_sw_sync;
    logic [4:0]  m_bmeta;
    logic [4:0]  m_hist [DEB];
    logic [4:0]  m_db, m_nd, m_rise, m_evt;
    logic [31:0] m_data;
    logic        m_valid, m_clr, m_flip;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_sw_meta = '0; m_sw_sync = '0; m_bmeta = '0;
            for (int j = 0; j < DEB; j++) m_hist[j] = '0;
            m_db = '0; m_evt = '0; m_data = '0; m_valid = 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                m_flip = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (m_hist[j][i] == m_db[i]) m_flip = 1'b0;
                m_nd[i] = m_flip ? ~m_db[i] : m_db[i];
            end
            m_rise  = m_nd & ~m_db;
            m_valid = 1'b0;
            m_clr   = 1'b0;
            if (bus_if.device == 5'd1) begin
                case (bus_if.command)
                    6'd2: begin m_data = 32'(m_sw_sync); m_valid = 1'b1; end
                    6'd3: begin m_data = 32'(m_db); m_valid = 1'b1; end
                    6'd4: begin m_data = 32'(m_evt); m_valid = 1'b1; m_clr = 1'b1; end
                    6'd5: begin m_data = (32'(m_db) << 8) | 32'(m_sw_sync); m_valid = 1'b1; end
                    default: ;
                endcase
            end
            m_evt = m_rise | (m_clr ? 5'd0 : m_evt);
            m_db  = m_nd;
            for (int j = DEB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = m_bmeta;
            m_bmeta   = buttons;
            m_sw_sync = m_sw_meta;
            m_sw_meta = switches;
        end
    end

    always begin
        @(negedge clk);
        #1;
        tests++;
        if (bus_if.data_out !== m_data) begin
            fails++;
            $display("FAIL model_data t=%0t: got %h expected %h", $time, bus_if.data_out, m_data);
        end
        tests++;
        if (bus_if.rd_valid !== m_valid) begin
            fails++;
            $display("FAIL model_valid t=%0t: got %b expected %b", $time, bus_if.rd_valid, m_valid);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmd(input logic [4:0] d, input logic [5:0] c);
        bus_if.device  = d;
        bus_if.command = c;
        @(negedge clk);
        bus_if.device  = 5'd0;
        bus_if.command = 6'd0;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] %s ok: %h", name, act);
        end
    endtask

    initial begin
        reset = 1'b0;
        switches = '0;
        buttons = '0;
        bus_if.device  = 5'd0;
        bus_if.command = 6'd0;

        // Reset with inputs toggling
        for (int k = 0; k < 4; k++) begin
            switches = 8'(k * 37 + 1);
            buttons  = 5'(k * 7 + 3);
            @(negedge clk);
        end
        lit("rst_data", bus_if.data_out, 32'h0);
        lit("rst_valid", 32'(bus_if.rd_valid), 32'h0);
        switches = '0;
        buttons  = '0;
        @(negedge clk);
        reset = 1'b1;
        cyc(3);
        cmd(5'd1, 6'd5);
        lit("status_data", bus_if.data_out, 32'h0);
        lit("status_valid", 32'(bus_if.rd_valid), 32'h1);
        cyc(1);
        lit("status_valid_drop", 32'(bus_if.rd_valid), 32'h0);

        // Switches, own device and foreign device
        switches = 8'hA5;
        cyc(3);
        cmd(5'd1, 6'd2);
        lit("sw_data", bus_if.data_out, 32'h000000A5);
        lit("sw_valid", 32'(bus_if.rd_valid), 32'h1);
        cmd(5'd0, 6'd2);
        lit("sw_foreign_valid", 32'(bus_if.rd_valid), 32'h0);
        lit("sw_foreign_hold", bus_if.data_out, 32'h000000A5);

        // Debounce: 3-cycle glitch rejected, 10-cycle hold accepted
        buttons = 5'b00100;
        cyc(3);
        buttons = 5'b00000;
        cyc(6);
        cmd(5'd1, 6'd3);
        lit("glitch_level", bus_if.data_out, 32'h0);
        cmd(5'd1, 6'd4);
        lit("glitch_evt", bus_if.data_out, 32'h0);
        buttons = 5'b00100;
        cyc(10);
        cmd(5'd1, 6'd3);
        lit("hold_level", bus_if.data_out, 32'h4);
        cmd(5'd1, 6'd4);
        lit("hold_evt", bus_if.data_out, 32'h4);
        cmd(5'd1, 6'd4);
        lit("hold_evt_cleared", bus_if.data_out, 32'h0);
        buttons = 5'b00000;
        cyc(8);

        // Set-vs-clear race
        buttons = 5'b00010;
        cyc(8);
        buttons = 5'b00000;
        cyc(8);
        buttons = 5'b00001;
        cyc(5);
        cmd(5'd1, 6'd4);
        lit("race_data", bus_if.data_out, 32'h2);
        lit("race_model_evt", 32'(m_evt), 32'h1);
        cmd(5'd1, 6'd4);
        lit("race_evt_after", bus_if.data_out, 32'h1);
        buttons = 5'b00000;
        cyc(8);

        // Illegal / foreign commands leave evt intact
        buttons = 5'b10000;
        cyc(8);
        buttons = 5'b00000;
        cyc(8);
        cmd(5'd1, 6'd1);
        lit("ill_cmd1_valid", 32'(bus_if.rd_valid), 32'h0);
        cmd(5'd1, 6'h3F);
        lit("ill_cmd3f_valid", 32'(bus_if.rd_valid), 32'h0);
        cmd(5'd0, 6'd4);
        lit("ill_dev0_valid", 32'(bus_if.rd_valid), 32'h0);
        cmd(5'd0, 6'd1);
        cmd(5'd1, 6'd4);
        lit("ill_evt_kept", bus_if.data_out, 32'h10);

        // Reset in the middle of a debounce count, button kept held
        buttons = 5'b10000;
        cyc(4);
        reset = 1'b0;
        #1;
        lit("midrst_data", bus_if.data_out, 32'h0);
        lit("midrst_valid", 32'(bus_if.rd_valid), 32'h0);
        cyc(2);
        reset = 1'b1;
        cyc(5);
        cmd(5'd1, 6'd3);
        lit("midrst_level_early", bus_if.data_out, 32'h0);
        cmd(5'd1, 6'd3);
        lit("midrst_level_accept", bus_if.data_out, 32'h10);
        cmd(5'd1, 6'd4);
        lit("midrst_evt", bus_if.data_out, 32'h10);
        buttons = 5'b00000;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/switches_buttons.md
Name: switches_buttons

Overview:
- Memory-mapped input peripheral; the read-side counterpart of the LED output peripheral on the same device/command bus.
- Synchronizes 8 slide switches and 5 push-buttons, debounces the buttons, and latches sticky rising-edge event flags.
- Returns the results on data_out when the CPU addresses this device with a read command.

Parameters:
- DEV_ID, 5'b00001, device-select value this block responds to.
- DEBOUNCE_CYCLES, 250000, cycles a synchronized button level must hold before it is accepted; must be >= 2.
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- device  input  5  bus device select.
- command  input  6  bus command.
- switches  input  8  raw slide switches, asynchronous to clk.
- buttons  input  5  raw push-buttons, asynchronous, active-high.
- data_out  output  32  registered read data.
- rd_valid  output  1  one-cycle pulse, data_out valid.

Behaviour:
- Reset (reset=0, asynchronous): all synchronizer flops, debounced levels, counters, event flags, data_out and rd_valid go to 0.
- Synchronizers:
  - Every switches and buttons bit passes through a 2-flop synchronizer.
  - Switches are not debounced. sw_sync lags the pin by 2 cycles.
- Debounce, per button i, with its own counter cnt[i]:
  - If btn_sync[i]==btn_db[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i]==DEBOUNCE_CYCLES-1: btn_db[i] <= btn_sync[i] and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_db.
  - An accepted change appears DEBOUNCE_CYCLES cycles after btn_sync changes, which is DEBOUNCE_CYCLES+2 cycles after the pin.
- Event flags:
  - evt[i] sets on the cycle btn_db[i] goes 0->1.
  - evt[i] stays set until a read-and-clear command. Falling edges are ignored.
- Bus decode: a command is accepted only in a cycle with device==DEV_ID. Commands are single-cycle; there are no wait states.
  - 6'b000010 read switches: data_out <= {24'd0, sw_sync}.
  - 6'b000011 read button levels: data_out <= {27'd0, btn_db}.
  - 6'b000100 read-and-clear events: data_out <= {27'd0, evt}, and evt is cleared in the same edge.
  - 6'b000101 read status: data_out <= {16'd0, 3'd0, btn_db, sw_sync}.
- Read latency:
  - An accepted read command updates data_out and raises rd_valid on the next rising edge. Latency is 1.
  - rd_valid is high for exactly that one cycle per accepted command. Back-to-back commands give back-to-back pulses.
  - In any cycle without an accepted read: rd_valid <= 0 and data_out holds its last value.
- Ignored commands:
  - Any other command, or device != DEV_ID (including the LED write 6'b000001 on device 0), produces no rd_valid and no state change.
  - evt is not cleared in those cases.
- Simultaneous events:
  - A rising edge on button i in the same cycle as read-and-clear: the returned data shows the old evt[i], and evt[i] ends the cycle SET. Set wins, so no event is lost.
  - Multiple buttons may set flags in the same cycle; each flag is independent.
- Mid-operation reset: reset asserted during a debounce count or while flags are pending clears everything immediately. After release, a button still held reads as a fresh press after the full debounce delay.
- Counters never wrap: cnt saturates by resetting at DEBOUNCE_CYCLES-1.

Test Plan (bench uses DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset: drive reset=0 with the inputs toggling -> data_out=0, rd_valid=0, evt=0. Release reset, issue read-status -> next cycle data_out=0, rd_valid=1 for one cycle.
- Switches: set switches=8'hA5, wait 3 cycles, issue device=1, cmd=000010 -> one cycle later data_out=32'h000000A5, rd_valid=1. Repeat with device=0 -> rd_valid stays 0.
- Debounce: pulse buttons[2] high for 3 cycles -> btn_db stays 0 and the event read returns 0. Hold high for 10 cycles -> level read returns 32'h4 and the event read returns 32'h4; a second event read returns 0.
- Set-vs-clear race: time the 4th stable cycle of buttons[0] to coincide with read-and-clear while evt=5'b00010 -> data_out=32'h2 and evt ends at 5'b00001.
- Illegal/foreign commands: device=1 with cmd=000001 and cmd=111111 while evt=5'b10000 -> no rd_valid, and evt remains 5'b10000.
- Reset mid-debounce: buttons[4] high, assert reset after 2 counted cycles, release -> press is accepted only 4 cycles after btn_sync is re-established.
